// File: rtl/vector_pe_sequencer.sv
// vector_pe_sequencer
//   Coprocessor-side initiator for the vector processing element (PE). It accepts one
//   vector command and, for each 32-bit word of the vector, reads vs1/vs2 from the
//   VRF, starts the PE, waits for pe_done and writes the result back to vd.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid_i/ready_o   command handshake (ready only while idle)
//   cmd_instr_i           PE opcode 00..05
//   cmd_vd/vs1/vs2_i      register indices
//   cmd_vl_i              element count
//   cmd_sew_i             element width (8/16/32, forced to 8 for the varp opcodes)
//   cmd_vap_i, cmd_opc_i  passed through to pe_vap_o / pe_opc_o
//   cmd_done_o, cmd_err_o end-of-command pulse and error flag
//   vrf_raddr_a/b_o       {reg, word} read addresses, data returns one cycle later
//   vrf_rdata_a/b_i       read data
//   vrf_we/waddr/wdata/wstrb_o  write port
//   pe_instruction/start/opa/opb/opc/sew/vap_o  PE command side
//   pe_done_i, pe_peout_i PE completion (level) and result
//
// Build option
//   VEC_SEQ_TIMEOUT_EN : when defined, a watchdog aborts a word whose pe_done does not
//                        arrive within TIMEOUT cycles of pe_start (cmd_err=1).
module vector_pe_sequencer #(
  parameter int VLEN_WORDS = 8,
  parameter int VL_W       = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [7:0]                    cmd_instr_i,
  input  logic [4:0]                    cmd_vd_i,
  input  logic [4:0]                    cmd_vs1_i,
  input  logic [4:0]                    cmd_vs2_i,
  input  logic [VL_W-1:0]               cmd_vl_i,
  input  logic [9:0]                    cmd_sew_i,
  input  logic [3:0]                    cmd_vap_i,
  input  logic [31:0]                   cmd_opc_i,
  output logic                          cmd_done_o,
  output logic                          cmd_err_o,
  output logic [4+$clog2(VLEN_WORDS):0] vrf_raddr_a_o,
  output logic [4+$clog2(VLEN_WORDS):0] vrf_raddr_b_o,
  input  logic [31:0]                   vrf_rdata_a_i,
  input  logic [31:0]                   vrf_rdata_b_i,
  output logic                          vrf_we_o,
  output logic [4+$clog2(VLEN_WORDS):0] vrf_waddr_o,
  output logic [31:0]                   vrf_wdata_o,
  output logic [3:0]                    vrf_wstrb_o,
  output logic [7:0]                    pe_instruction_o,
  output logic                          pe_start_o,
  output logic [31:0]                   pe_opa_o,
  output logic [31:0]                   pe_opb_o,
  output logic [31:0]                   pe_opc_o,
  output logic [9:0]                    pe_sew_o,
  output logic [3:0]                    pe_vap_o,
  input  logic                          pe_done_i,
  input  logic [31:0]                   pe_peout_i
);

  localparam int KW = $clog2(VLEN_WORDS);
  localparam int CW = (VL_W > KW + 3) ? VL_W : KW + 3;
  // Maximum element counts per SEW: a whole vector register holds 4*VLEN_WORDS bytes.
  localparam logic [KW+2:0] MAX_E8  = (KW+3)'(VLEN_WORDS * 4);
  localparam logic [KW+2:0] MAX_E16 = (KW+3)'(VLEN_WORDS * 2);
  localparam logic [KW+2:0] MAX_E32 = (KW+3)'(VLEN_WORDS);

  if (VLEN_WORDS < 2 || TIMEOUT < 1) begin : g_param_check
    $error("vector_pe_sequencer: VLEN_WORDS must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    instr_q;
  logic [4:0]    vd_q, vs1_q, vs2_q;
  logic [9:0]    sew_q;
  logic [3:0]    vap_q, lstrb_q;
  logic [31:0]   opc_q, opa_q, opb_q, res_q;
  logic [KW:0]   words_q;
  logic [KW-1:0] k_q;
  logic          err_q, first_q;

  // Command decode, evaluated on the raw command inputs and registered at accept.
  logic [9:0]    sew_eff;
  logic [1:0]    sew_sh;
  logic          sew_ok, op_ok, cmd_bad;
  logic [KW+2:0] max_el, vl_c, n_bytes;
  logic [CW-1:0] vl_w;
  logic [KW:0]   words_c;
  logic [3:0]    lstrb_c;

  always_comb begin
    sew_eff = (cmd_instr_i >= 8'h03) ? 10'd8 : cmd_sew_i;
    op_ok   = (cmd_instr_i <= 8'h05);
    sew_ok  = 1'b1;
    sew_sh  = 2'd0;
    max_el  = MAX_E8;
    case (sew_eff)
      10'd8:   begin sew_sh = 2'd0; max_el = MAX_E8;  end
      10'd16:  begin sew_sh = 2'd1; max_el = MAX_E16; end
      10'd32:  begin sew_sh = 2'd2; max_el = MAX_E32; end
      default: sew_ok = 1'b0;
    endcase
    cmd_bad = !(op_ok && sew_ok);
    vl_w    = CW'(cmd_vl_i);
    vl_c    = (vl_w > CW'(max_el)) ? max_el : vl_w[KW+2:0];
    n_bytes = vl_c << sew_sh;
    words_c = n_bytes[KW+2:2] + (KW+1)'(|n_bytes[1:0]);
    // Last-word strobe covers only the bytes holding active elements.
    case (n_bytes[1:0])
      2'd1:    lstrb_c = 4'b0001;
      2'd2:    lstrb_c = 4'b0011;
      2'd3:    lstrb_c = 4'b0111;
      default: lstrb_c = 4'b1111;
    endcase
  end

  logic accept, last_word;
  assign accept    = cmd_valid_i && (state_q == S_IDLE);
  assign last_word = ({1'b0, k_q} == (words_q - (KW+1)'(1)));

`ifdef VEC_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_q;

  // Counts cycles spent in WAIT; zero in the pe_start cycle.
  always_ff @(posedge clk) begin
    if (reset)                   tmo_q <= '0;
    else if (state_q == S_LATCH) tmo_q <= '0;
    else if (state_q == S_WAIT)  tmo_q <= tmo_q + TW'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    cmd_ready_o   = 1'b0;
    cmd_done_o    = 1'b0;
    cmd_err_o     = 1'b0;
    vrf_raddr_a_o = '0;
    vrf_raddr_b_o = '0;
    vrf_we_o      = 1'b0;
    vrf_waddr_o   = '0;
    vrf_wdata_o   = '0;
    vrf_wstrb_o   = '0;
    pe_start_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = (cmd_bad || words_c == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        vrf_raddr_a_o = {vs1_q, k_q};
        vrf_raddr_b_o = {vs2_q, k_q};
        state_d       = S_LATCH;
      end
      S_LATCH: state_d = S_WAIT;
      S_WAIT: begin
        // pe_done may still be high from the previous word in the start cycle.
        pe_start_o = first_q;
        if (!first_q && pe_done_i) state_d = S_WRITE;
`ifdef VEC_SEQ_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) state_d = S_DONE;
`endif
      end
      S_WRITE: begin
        vrf_we_o    = 1'b1;
        vrf_waddr_o = {vd_q, k_q};
        vrf_wdata_o = res_q;
        vrf_wstrb_o = last_word ? lstrb_q : 4'hF;
        state_d     = last_word ? S_DONE : S_READ;
      end
      S_DONE: begin
        cmd_done_o = 1'b1;
        cmd_err_o  = err_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0; vd_q <= '0; vs1_q <= '0; vs2_q <= '0;
      sew_q   <= '0; vap_q <= '0; opc_q <= '0; lstrb_q <= '0;
      words_q <= '0; k_q <= '0; err_q <= 1'b0; first_q <= 1'b0;
      opa_q   <= '0; opb_q <= '0; res_q <= '0;
    end else begin
      if (accept) begin
        instr_q <= cmd_instr_i;
        vd_q    <= cmd_vd_i;
        vs1_q   <= cmd_vs1_i;
        vs2_q   <= cmd_vs2_i;
        sew_q   <= sew_eff;
        vap_q   <= cmd_vap_i;
        opc_q   <= cmd_opc_i;
        words_q <= words_c;
        lstrb_q <= lstrb_c;
        err_q   <= cmd_bad;
        k_q     <= '0;
      end
      case (state_q)
        S_LATCH: begin
          opa_q   <= vrf_rdata_a_i;
          opb_q   <= vrf_rdata_b_i;
          first_q <= 1'b1;
        end
        S_WAIT: begin
          first_q <= 1'b0;
          if (!first_q && pe_done_i) res_q <= pe_peout_i;
        end
        S_WRITE: if (!last_word) k_q <= k_q + KW'(1);
        default: ;
      endcase
`ifdef VEC_SEQ_TIMEOUT_EN
      if (state_q == S_WAIT && state_d == S_DONE) err_q <= 1'b1;
`endif
    end
  end

  assign pe_instruction_o = instr_q;
  assign pe_opa_o         = opa_q;
  assign pe_opb_o         = opb_q;
  assign pe_opc_o         = opc_q;
  assign pe_sew_o         = sew_q;
  assign pe_vap_o         = vap_q;

endmodule
